alu_issue_ctrl: RTL and testbench

- Front-end sequencer for the 16-bit execution unit.
- Accepts packed 16-bit ALU instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the execution unit's operanda/operandb/alu_op inputs, samples its result, zero and carry outputs, then writes the result back and updates flags.
- Sits between the instruction fetch/decode path and Execution_Unit.

---
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Serial issue sequencer for the 16-bit execution unit: accepts one instruction,
// reads operands from an 8x16 register file, drives the EU, and writes the result back.
module alu_issue_ctrl #(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned RIDX_W = 3,
  parameter int unsigned DW     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DW-1:0]     eu_operanda,
  output logic [DW-1:0]     eu_operandb,
  output logic [2:0]        eu_alu_op,
  input  logic [DW-1:0]     eu_result,
  input  logic [DW-1:0]     eu_carry,
  input  logic              eu_zero,
  output logic              wb_valid,
  output logic [RIDX_W-1:0] wb_rd,
  output logic [DW-1:0]     wb_data,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [RIDX_W-1:0] dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e             state_q;
  logic               ready_q;
  logic [15:0]        instr_q;
  logic [DW-1:0]      opa_q;
  logic [DW-1:0]      opb_q;
  logic [2:0]         alu_op_q;
  logic [DW-1:0]      res_q;
  logic               zero_q;
  logic               carry_q;
  logic               wb_valid_q;
  logic [RIDX_W-1:0]  wb_rd_q;
  logic [DW-1:0]      wb_data_q;
  logic               flag_z_q;
  logic               flag_c_q;
  logic [DW-1:0]      regs_q [NREGS];

  // Decoded fields of the latched instruction
  logic [2:0]         op_d;
  logic [2:0]         rd_d;
  logic [2:0]         rs1_d;
  logic [2:0]         rs2_d;
  logic               imm_sel_d;
  logic [5:0]         imm_d;
  logic [DW-1:0]      rs1_data_d;
  logic [DW-1:0]      rs2_data_d;

  assign op_d      = instr_q[15:13];
  assign rd_d      = instr_q[12:10];
  assign rs1_d     = instr_q[9:7];
  assign imm_sel_d = instr_q[6];
  assign rs2_d     = instr_q[5:3];
  assign imm_d     = instr_q[5:0];

  // r0 is hard-wired to zero on every read port
  assign rs1_data_d = (rs1_d == 3'd0) ? '0 : regs_q[rs1_d];
  assign rs2_data_d = (rs2_d == 3'd0) ? '0 : regs_q[rs2_d];
  assign dbg_data   = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  // Only the EU carry MSB and the non-reserved instruction bits carry meaning
  logic unused_bits;
  assign unused_bits = ^{eu_carry[DW-2:0], instr_q[2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      instr_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      alu_op_q   <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid && ready_q) begin
            instr_q <= instr;
            ready_q <= 1'b0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          alu_op_q <= op_d;
          opa_q    <= rs1_data_d;
          opb_q    <= imm_sel_d ? DW'(imm_d) : rs2_data_d;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          // EU is combinational; its outputs settle during this cycle
          res_q      <= eu_result;
          zero_q     <= eu_zero;
          carry_q    <= eu_carry[DW-1];
          wb_valid_q <= 1'b1;
          wb_rd_q    <= RIDX_W'(rd_d);
          wb_data_q  <= eu_result;
          state_q    <= S_WB;
        end
        S_WB: begin
          if (rd_d != 3'd0) begin
            regs_q[rd_d] <= res_q;
          end
          flag_z_q   <= zero_q;
          flag_c_q   <= carry_q;
          wb_valid_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign eu_operanda = opa_q;
  assign eu_operandb = opb_q;
  assign eu_alu_op   = alu_op_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural execution unit (op 1 = add).
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] eu_operanda;
  logic [15:0] eu_operandb;
  logic [2:0]  eu_alu_op;
  logic [15:0] eu_result;
  logic [15:0] eu_carry;
  logic        eu_zero;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flag_z;
  logic        flag_c;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  // Override lets a step force an arbitrary EU response (used to preload registers)
  logic        ovr_en;
  logic [15:0] ovr_res;
  logic        ovr_zero;
  logic        ovr_carry;
  logic [16:0] sum;

  int passed = 0;
  int total  = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .eu_operanda (eu_operanda),
    .eu_operandb (eu_operandb),
    .eu_alu_op   (eu_alu_op),
    .eu_result   (eu_result),
    .eu_carry    (eu_carry),
    .eu_zero     (eu_zero),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    sum       = {1'b0, eu_operanda} + {1'b0, eu_operandb};
    eu_result = '0;
    eu_carry  = '0;
    eu_zero   = 1'b1;
    if (ovr_en) begin
      eu_result = ovr_res;
      eu_carry  = {ovr_carry, 15'd0};
      eu_zero   = ovr_zero;
    end else if (eu_alu_op == 3'd1) begin
      eu_result = sum[15:0];
      eu_carry  = {sum[16], 15'd0};
      eu_zero   = (sum[15:0] == 16'd0);
    end
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
  endtask

  function automatic logic [15:0] mk_imm(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [5:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [15:0] mk_reg(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 3'b000};
  endfunction

  // Called at a negedge; returns just after the accepting posedge
  task automatic issue(input string tag, input logic [15:0] ins);
    int lat;
    lat = -1;
    instr       = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      if (instr_ready) begin
        lat = i;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    chk(tag, "accept_wait", lat, 0);
  endtask

  // Walks READ, EXEC, WB and the following IDLE cycle of an accepted instruction
  task automatic follow(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] rd, input logic [15:0] data,
                        input logic [15:0] reg_exp, input logic z, input logic c);
    @(negedge clk);
    instr_valid = 1'b0;
    chk(tag, "ready_read", instr_ready, 1'b0);
    chk(tag, "wbv_read", wb_valid, 1'b0);
    @(negedge clk);
    chk(tag, "ready_exec", instr_ready, 1'b0);
    chk(tag, "alu_op", eu_alu_op, op);
    chk(tag, "operanda", eu_operanda, a);
    chk(tag, "operandb", eu_operandb, b);
    chk(tag, "wbv_exec", wb_valid, 1'b0);
    @(negedge clk);
    chk(tag, "ready_wb", instr_ready, 1'b0);
    chk(tag, "wbv_wb", wb_valid, 1'b1);
    chk(tag, "wb_rd", wb_rd, rd);
    chk(tag, "wb_data", wb_data, data);
    dbg_addr = rd;
    @(negedge clk);
    chk(tag, "ready_idle", instr_ready, 1'b1);
    chk(tag, "wbv_idle", wb_valid, 1'b0);
    chk(tag, "wb_data_hold", wb_data, data);
    chk(tag, "flag_z", flag_z, z);
    chk(tag, "flag_c", flag_c, c);
    chk(tag, "regfile", dbg_data, reg_exp);
  endtask

  initial begin
    int acc;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    ovr_en      = 1'b0;
    ovr_res     = '0;
    ovr_zero    = 1'b0;
    ovr_carry   = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset", "instr_ready", instr_ready, 1'b1);
    chk("reset", "wb_valid", wb_valid, 1'b0);
    chk("reset", "wb_rd", wb_rd, 3'd0);
    chk("reset", "wb_data", wb_data, 16'd0);
    chk("reset", "flags", {flag_z, flag_c}, 2'b00);
    chk("reset", "eu_ops", {eu_alu_op, eu_operanda, eu_operandb}, 35'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("reset", "dbg", dbg_data, 16'd0);
    end

    // Immediate load R1 = 0 + 0x2A
    issue("imm_load", mk_imm(3'd1, 3'd1, 3'd0, 6'h2A));
    follow("imm_load", 3'd1, 16'h0000, 16'h002A, 3'd1, 16'h002A, 16'h002A, 1'b0, 1'b0);

    // Preload R2 = 0xFFFF through a forced EU response, R3 = 0 + 1
    ovr_en = 1'b1; ovr_res = 16'hFFFF; ovr_zero = 1'b0; ovr_carry = 1'b0;
    issue("pre_r2", mk_imm(3'd1, 3'd2, 3'd0, 6'h00));
    follow("pre_r2", 3'd1, 16'h0000, 16'h0000, 3'd2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    ovr_en = 1'b0;
    issue("pre_r3", mk_imm(3'd1, 3'd3, 3'd0, 6'h01));
    follow("pre_r3", 3'd1, 16'h0000, 16'h0001, 3'd3, 16'h0001, 16'h0001, 1'b0, 1'b0);

    // Register-register add wrapping to zero with carry out
    issue("rr_flags", mk_reg(3'd1, 3'd4, 3'd2, 3'd3));
    follow("rr_flags", 3'd1, 16'hFFFF, 16'h0001, 3'd4, 16'h0000, 16'h0000, 1'b1, 1'b1);

    // Undefined opcode passes through; EU returns 0 which overwrites R3
    issue("op_undef", mk_reg(3'd5, 3'd3, 3'd2, 3'd2));
    follow("op_undef", 3'd5, 16'hFFFF, 16'hFFFF, 3'd3, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // r0 write is reported but never stored
    ovr_en = 1'b1; ovr_res = 16'h1234; ovr_zero = 1'b0; ovr_carry = 1'b0;
    issue("r0_write", mk_imm(3'd1, 3'd0, 3'd1, 6'h05));
    follow("r0_write", 3'd1, 16'h002A, 16'h0005, 3'd0, 16'h1234, 16'h0000, 1'b0, 1'b0);
    ovr_en = 1'b0;
    issue("r0_read", mk_imm(3'd1, 3'd5, 3'd0, 6'h07));
    follow("r0_read", 3'd1, 16'h0000, 16'h0007, 3'd5, 16'h0007, 16'h0007, 1'b0, 1'b0);

    // Back-to-back with instr_valid held: R6 = R1 + 0x10, then R7 = R6 + R5
    instr       = mk_imm(3'd1, 3'd6, 3'd1, 6'h10);
    instr_valid = 1'b1;
    chk("b2b", "ready_first", instr_ready, 1'b1);
    @(posedge clk);
    acc = 0;
    for (int i = 1; i <= 20 && acc == 0; i++) begin
      @(negedge clk);
      if (i == 1) instr = mk_reg(3'd1, 3'd7, 3'd6, 3'd5);
      if (instr_ready) begin
        acc = i;
        @(posedge clk);
      end
    end
    chk("b2b", "accept_gap", acc, 4);
    follow("b2b", 3'd1, 16'h003A, 16'h0007, 3'd7, 16'h0041, 16'h0041, 1'b0, 1'b0);
    dbg_addr = 3'd6;
    #1;
    chk("b2b", "r6", dbg_data, 16'h003A);

    // Reset during EXEC aborts the instruction; valid held low-reset is ignored
    issue("rst_mid", mk_imm(3'd1, 3'd6, 3'd0, 6'h11));
    dbg_addr = 3'd6;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid", "operandb_exec", eu_operandb, 16'h0011);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", "wbv_rst1", wb_valid, 1'b0);
    @(negedge clk);
    chk("rst_mid", "wbv_rst2", wb_valid, 1'b0);
    chk("rst_mid", "ready_rst", instr_ready, 1'b1);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid", "ready_after", instr_ready, 1'b1);
    chk("rst_mid", "wbv_after", wb_valid, 1'b0);
    chk("rst_mid", "r6", dbg_data, 16'h0000);
    chk("rst_mid", "flags", {flag_z, flag_c}, 2'b00);
    chk("rst_mid", "wb_data", wb_data, 16'h0000);
    issue("post_rst", mk_imm(3'd1, 3'd1, 3'd0, 6'h03));
    follow("post_rst", 3'd1, 16'h0000, 16'h0003, 3'd1, 16'h0003, 16'h0003, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
